// File: rtl/dac_ramp_sequencer.sv
// -----------------------------------------------------------------------------
// dac_ramp_sequencer
//
// Purpose
//   Upstream feeder for the I2C DAC writer. It accepts 12-bit target setpoints
//   over a valid/ready port and slews the DAC code toward the newest target in
//   steps of at most `step` codes. It issues no more than one write request per
//   UPDATE_PERIOD cycles. It paces itself on the writer's busy output, and a
//   watchdog abandons a request that the writer never accepts.
//
// Parameters
//   UPDATE_PERIOD  minimum clk cycles between successive write requests (>= 2)
//   ACCEPT_TIMEOUT cycles dac_enable may stay high without busy rising (>= 1)
//   RESET_CODE     DAC code assumed and driven after reset
//
// Ports
//   clk          in   1   system clock
//   rst          in   1   asynchronous reset, active-high
//   tgt_value    in   12  requested DAC code
//   tgt_valid    in   1   tgt_value valid
//   tgt_ready    out  1   always 1; a target is taken on every valid cycle
//   step         in   12  max code change per write; 0 = jump straight to target
//   dac_busy     in   1   writer busy (low only while ready for a new request)
//   dac_enable   out  1   write request to the DAC writer
//   dac_value    out  12  code presented to the writer, stable while enabled
//   cur_value    out  12  last code the writer accepted
//   at_target    out  1   idle with cur_value == target
//   timeout_err  out  1   one-cycle pulse when the accept watchdog expires
// -----------------------------------------------------------------------------
module dac_ramp_sequencer #(
  parameter int          UPDATE_PERIOD  = 20000,
  parameter int          ACCEPT_TIMEOUT = 4096,
  parameter logic [11:0] RESET_CODE     = 12'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] tgt_value,
  input  logic        tgt_valid,
  output logic        tgt_ready,
  input  logic [11:0] step,
  input  logic        dac_busy,
  output logic        dac_enable,
  output logic [11:0] dac_value,
  output logic [11:0] cur_value,
  output logic        at_target,
  output logic        timeout_err
);

  // UPDATE_PERIOD-1 always fits in $clog2(UPDATE_PERIOD) bits for UPDATE_PERIOD >= 2.
  localparam int PW = $clog2(UPDATE_PERIOD);
  localparam int WW = (ACCEPT_TIMEOUT > 1) ? $clog2(ACCEPT_TIMEOUT) : 1;

  localparam logic [PW-1:0] PERIOD_LAST = PW'(UPDATE_PERIOD - 1);
  localparam logic [WW-1:0] WD_LAST     = WW'(ACCEPT_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t        state_reg,     state_next;
  logic [11:0]   target_reg,    target_next;
  logic [11:0]   cur_reg,       cur_next;
  logic [11:0]   dac_value_reg, dac_value_next;
  logic          enable_reg,    enable_next;
  logic          timeout_reg,   timeout_next;
  logic [PW-1:0] period_reg,    period_next;
  logic [WW-1:0] wd_reg,        wd_next;

  // ---------------------------------------------------------------------------
  // Next code toward the target. The upward sum is carried in 13 bits so that
  // cur+step beyond 0xFFF clamps to the target instead of wrapping. The
  // downward path compares the step with the remaining distance before
  // subtracting, so the subtraction cannot go below zero.
  // ---------------------------------------------------------------------------
  logic [12:0] sum_up;
  logic [11:0] dist_down;
  logic [11:0] next_code;

  always_comb begin
    sum_up    = {1'b0, cur_reg} + {1'b0, step};
    dist_down = cur_reg - target_reg;  // only used when cur_reg > target_reg
    next_code = target_reg;
    if (step != 12'd0) begin
      if (cur_reg < target_reg) begin
        if (sum_up < {1'b0, target_reg}) begin
          next_code = sum_up[11:0];
        end
      end else if (cur_reg > target_reg) begin
        if (step < dist_down) begin
          next_code = cur_reg - step;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    cur_next       = cur_reg;
    dac_value_next = dac_value_reg;
    enable_next    = enable_reg;
    timeout_next   = 1'b0;
    wd_next        = wd_reg;
    // The period counter free-runs up to its last value and waits there.
    period_next    = (period_reg == PERIOD_LAST) ? period_reg : period_reg + 1'b1;
    // tgt_ready is constantly high, so every valid cycle is a handshake and
    // the newest target simply overwrites the old one. The write decision in
    // IDLE reads the registered target, so a handshake that coincides with
    // the end of a write steers the following step.
    target_next    = tgt_valid ? tgt_value : target_reg;

    case (state_reg)
      IDLE: begin
        if ((target_reg != cur_reg) && (period_reg == PERIOD_LAST)) begin
          dac_value_next = next_code;
          enable_next    = 1'b1;
          period_next    = '0;
          wd_next        = '0;
          state_next     = ISSUE;
        end
      end

      ISSUE: begin
        // Busy low at entry means the writer is ready. Acceptance is busy
        // rising, which also marks the code as handed over.
        if (dac_busy) begin
          enable_next = 1'b0;
          cur_next    = dac_value_reg;
          state_next  = WAIT_DONE;
        end else if (wd_reg == WD_LAST) begin
          // Give up on this request. The period counter is restarted so the
          // retry is spaced a full UPDATE_PERIOD after the abandoned request.
          enable_next  = 1'b0;
          timeout_next = 1'b1;
          period_next  = '0;
          state_next   = IDLE;
        end else begin
          wd_next = wd_reg + 1'b1;
        end
      end

      WAIT_DONE: begin
        if (!dac_busy) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next  = IDLE;
        enable_next = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      target_reg    <= RESET_CODE;
      cur_reg       <= RESET_CODE;
      dac_value_reg <= RESET_CODE;
      enable_reg    <= 1'b0;
      timeout_reg   <= 1'b0;
      // Start with the period already elapsed so the first write goes out
      // on the cycle after the first target arrives.
      period_reg    <= PERIOD_LAST;
      wd_reg        <= '0;
    end else begin
      state_reg     <= state_next;
      target_reg    <= target_next;
      cur_reg       <= cur_next;
      dac_value_reg <= dac_value_next;
      enable_reg    <= enable_next;
      timeout_reg   <= timeout_next;
      period_reg    <= period_next;
      wd_reg        <= wd_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs.
  // ---------------------------------------------------------------------------
  assign tgt_ready   = 1'b1;
  assign dac_enable  = enable_reg;
  assign dac_value   = dac_value_reg;
  assign cur_value   = cur_reg;
  assign timeout_err = timeout_reg;
  assign at_target   = (state_reg == IDLE) && (target_reg == cur_reg);

endmodule

// File: tb/tb_dac_ramp_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dac_ramp_sequencer
//   Self-checking bench for dac_ramp_sequencer. A behavioural writer model
//   raises busy for BUSY_LEN cycles per accepted request and compares each
//   accepted code against a queue of expected codes pushed with the stimulus.
// -----------------------------------------------------------------------------
module tb_dac_ramp_sequencer;

  localparam int UP       = 64;
  localparam int AT       = 32;
  localparam int BUSY_LEN = 50;

  logic        clk;
  logic        rst;
  logic [11:0] tgt_value;
  logic        tgt_valid;
  logic        tgt_ready;
  logic [11:0] step;
  logic        dac_busy;
  logic        dac_enable;
  logic [11:0] dac_value;
  logic [11:0] cur_value;
  logic        at_target;
  logic        timeout_err;

  dac_ramp_sequencer #(
    .UPDATE_PERIOD (UP),
    .ACCEPT_TIMEOUT(AT),
    .RESET_CODE    (12'd0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tgt_value  (tgt_value),
    .tgt_valid  (tgt_valid),
    .tgt_ready  (tgt_ready),
    .step       (step),
    .dac_busy   (dac_busy),
    .dac_enable (dac_enable),
    .dac_value  (dac_value),
    .cur_value  (cur_value),
    .at_target  (at_target),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard of codes the writer is expected to accept, in order.
  logic [11:0] exp_q[$];
  bit          deaf    = 1'b0;   // writer never raises busy while set
  bit          last_ok = 1'b0;
  int          last_acc = 0;
  int          wr_count = 0;

  // Writer model: acts on the falling edge, away from the DUT's active edge.
  initial begin
    int busy_cnt;
    logic [11:0] e;
    dac_busy = 1'b0;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (dac_busy) begin
        busy_cnt--;
        if (busy_cnt == 0) dac_busy = 1'b0;
      end else if (dac_enable && !deaf && !rst) begin
        wr_count++;
        check_val("write_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_val("write_code", 32'(dac_value), 32'(e));
          $display("write %0d: code=0x%03h expected=0x%03h cycle=%0d", wr_count, dac_value, e, cyc);
        end
        if (last_ok) check_val("write_spacing", 32'((cyc - last_acc) >= UP), 1);
        last_acc = cyc;
        last_ok  = 1'b1;
        dac_busy = 1'b1;
        busy_cnt = BUSY_LEN;
      end
    end
  end

  // Present one target for one cycle; optionally check the N / N+1 latency.
  task automatic send(input logic [11:0] v, input logic [11:0] s, input bit chk_lat);
    step      = s;
    tgt_value = v;
    tgt_valid = 1'b1;
    @(negedge clk);
    tgt_valid = 1'b0;
    if (chk_lat) begin
      check_val("latency_edge_n", 32'(dac_enable), 0);
      @(negedge clk);
      check_val("latency_edge_n1", 32'(dac_enable), 1);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(at_target && !dac_busy && exp_q.size() == 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_at_target"}, 32'(at_target), 1);
    check_val({tag, "_drained"}, 32'(exp_q.size()), 0);
  endtask

  task automatic wait_en(input logic lvl, output int at);
    int n = 0;
    bit ok = 1'b0;
    while (n < 500) begin
      @(negedge clk);
      n++;
      if (dac_enable == lvl) begin
        ok = 1'b1;
        break;
      end
    end
    at = cyc;
    check_val("wait_enable", 32'(ok), 1);
  endtask

  initial begin
    int t_rise, t_fall, t_retry, n;
    bit en_seen;
    rst = 1'b1; tgt_valid = 1'b0; tgt_value = 12'd0; step = 12'd0; deaf = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_enable", 32'(dac_enable), 0);
    check_val("rst_dac_value", 32'(dac_value), 0);
    check_val("rst_cur_value", 32'(cur_value), 0);
    check_val("rst_at_target", 32'(at_target), 1);
    check_val("rst_tgt_ready", 32'(tgt_ready), 1);
    check_val("rst_timeout", 32'(timeout_err), 0);
    rst = 1'b0;

    // 1: ramp 0 -> 0x800 in 0x100 steps, first write one cycle after handshake.
    for (int i = 1; i <= 8; i++) exp_q.push_back(12'(i * 256));
    send(12'h800, 12'h100, 1'b1);
    wait_idle("t1");
    check_val("t1_cur", 32'(cur_value), 32'h800);
    en_seen = 1'b0;
    repeat (2 * UP) begin
      @(negedge clk);
      if (dac_enable) en_seen = 1'b1;
    end
    check_val("t1_no_extra_write", 32'(en_seen), 0);

    // 2: downward ramp clamps at the target.
    exp_q.push_back(12'h500); exp_q.push_back(12'h200); exp_q.push_back(12'h010);
    send(12'h010, 12'h300, 1'b0);
    wait_idle("t2");
    check_val("t2_cur", 32'(cur_value), 32'h010);

    // 3: no wrap near full scale; step 0 jumps.
    exp_q.push_back(12'hF00);
    send(12'hF00, 12'h000, 1'b0);
    wait_idle("t3a");
    exp_q.push_back(12'hFFF);
    send(12'hFFF, 12'h200, 1'b0);
    wait_idle("t3b");
    check_val("t3_cur_full", 32'(cur_value), 32'hFFF);
    exp_q.push_back(12'h123);
    send(12'h123, 12'h000, 1'b0);
    wait_idle("t3c");
    check_val("t3_cur_jump", 32'(cur_value), 32'h123);

    // 4: retarget while a write is in WAIT_DONE.
    exp_q.push_back(12'h223);
    send(12'hC00, 12'h100, 1'b0);
    n = 0;
    while (!dac_busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_val("t4_busy_seen", 32'(dac_busy), 1);
    repeat (5) @(negedge clk);
    check_val("t4_enable_low", 32'(dac_enable), 0);
    exp_q.push_back(12'h123); exp_q.push_back(12'h100);
    send(12'h100, 12'h100, 1'b0);
    wait_idle("t4");
    check_val("t4_cur", 32'(cur_value), 32'h100);

    // 5: writer never accepts -> watchdog, pulse, retry one period later.
    deaf = 1'b1;
    send(12'h200, 12'h000, 1'b0);
    wait_en(1'b1, t_rise);
    wait_en(1'b0, t_fall);
    check_val("t5_enable_high_cycles", 32'(t_fall - t_rise), 32'(AT));
    check_val("t5_timeout_pulse", 32'(timeout_err), 1);
    check_val("t5_cur_unchanged", 32'(cur_value), 32'h100);
    @(negedge clk);
    check_val("t5_timeout_one_cycle", 32'(timeout_err), 0);
    wait_en(1'b1, t_retry);
    check_val("t5_retry_gap", 32'(t_retry - t_fall), 32'(UP));
    check_val("t5_retry_code", 32'(dac_value), 32'h200);
    exp_q.push_back(12'h200);
    deaf = 1'b0;
    wait_idle("t5");
    check_val("t5_cur", 32'(cur_value), 32'h200);

    // 6: asynchronous reset while a request is pending.
    deaf = 1'b1;
    send(12'h300, 12'h000, 1'b0);
    wait_en(1'b1, t_rise);
    #2 rst = 1'b1;
    #1;
    check_val("t6_async_enable", 32'(dac_enable), 0);
    check_val("t6_async_dac_value", 32'(dac_value), 0);
    check_val("t6_async_cur", 32'(cur_value), 0);
    check_val("t6_async_at_target", 32'(at_target), 1);
    @(negedge clk);
    rst = 1'b0;
    deaf = 1'b0;
    last_ok = 1'b0;
    exp_q.push_back(12'h050);
    send(12'h050, 12'h000, 1'b1);
    wait_idle("t6");
    check_val("t6_cur", 32'(cur_value), 32'h050);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

endmodule
